alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit ALU datapath (add, shift-left, shift-right, and, or, xor, nand, compare). It accepts operation requests from two independent requesters over valid/ready handshakes and issues one operation at a time to the ALU. It returns each registered result, tagged with the requester ID, on a single backpressured response channel. It sits between the TinyCPU decode stage (port 0) and the auxiliary/debug requester (port 1) and the ALU.

## Interface
- No parameters; datapath width fixed at 8, opcode width fixed at 3.
- Clock and reset: one clock `clk`. `rst_n` is synchronous, active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / 1
- `req0_ready` / `req1_ready`  out  1  port 0 / 1 request accepted this cycle
- `req0_op` / `req1_op`  in  3  opcode: 0 add, 1 shl A, 2 shr A, 3 and, 4 or, 5 xor, 6 nand, 7 compare
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  requester that issued the result
- `rsp_data`  out  8  ALU result
- `rsp_zero`, `rsp_carry`  out  1  flags (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any `reqN_valid` is high, arbitrate, assert the winner's ready, latch op/A/B/id, then go to EXEC.
  - EXEC: compute the ALU function on the latched operands, register the result and flags, then go to RESP.
  - RESP: `rsp_valid` is high. On `rsp_ready`:
    - If any request is valid, accept the next one in the same cycle and go to EXEC.
    - Otherwise go to IDLE.
- Only one operation is outstanding at a time. Both readys are low in EXEC, and low in RESP while `rsp_ready` is low.
- At most one `reqN_ready` is high in any cycle. A ready is never asserted without the matching valid.
- Arbitration is round-robin via a 1-bit last-grant pointer:
  - With a single valid requester, that requester wins.
  - With both valid, the requester not granted last wins.
  - The pointer updates only on an accepted grant.
- Arithmetic rules:
  - Add wraps modulo 256.
  - shl/shr shift A by one and zero-fill; B is ignored.
  - nand is ~(A&B).
  - Compare is unsigned: 8'hFF if A>=B, else 8'h00.
- Response outputs (`rsp_id`, `rsp_data`, flags) stay stable while `rsp_valid` is high and `rsp_ready` is low.
- Requesters may drop `reqN_valid` before a grant; no ordering between ports is guaranteed beyond round-robin fairness.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE and the pointer to "last=1", so port 0 wins the first tie.
  - `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_zero`, `rsp_carry` all clear to 0; both readys are 0.
  - An in-flight operation or pending response is discarded.
- Latency: handshake in cycle N gives `rsp_valid` high in cycle N+2.
- Throughput: one result per 2 cycles when `rsp_ready` is held high and a request is always pending. The RESP→EXEC back-to-back accept removes the IDLE bubble.
- Readys are combinational from state, valids, pointer and `rsp_ready`. All outputs other than readys are registered.

## Configuration
- `ALU_ARB_FLAGS_EN` defined:
  - `rsp_zero` = (result==0).
  - `rsp_carry` = bit 8 of A+B for add, A[7] for shl, A[0] for shr, and 0 for all other ops.
  - Both flags are registered with the result.
- Not defined: `rsp_zero` and `rsp_carry` are tied to 0 and no flag logic is synthesized; all other behaviour is identical.

## Test plan
- Reset, then port 0 only with op=0, A=8'hF0, B=8'h20 → accepted in cycle N. In cycle N+2: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8'h10; with flags enabled, `rsp_carry`=1, `rsp_zero`=0.
- Both ports continuously valid (port 0 op=3 A=8'hFF B=8'h0F, port 1 op=7 A=8'h05 B=8'h06), `rsp_ready`=1 → grants alternate 0,1,0,1. Responses alternate 8'h0F and 8'h00, with a new `rsp_valid` every 2 cycles.
- `rsp_ready` held low 5 cycles during RESP with port 1 valid → `req1_ready` stays 0 and `rsp_data`/`rsp_id` stay stable. When `rsp_ready` rises, port 1 is accepted in the same cycle.
- Port 1 op=1 A=8'h81 then op=2 A=8'h81 → results 8'h02 (carry 1), then 8'h40 (carry 1). Op=6 A=8'hFF B=8'hFF → 8'h00, zero=1.
- `rst_n` asserted during EXEC → next cycle state is IDLE and `rsp_valid`=0. With both ports then valid after reset, port 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin sequencer for the shared 8-bit ALU; define ALU_ARB_FLAGS_EN for zero/carry flags
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_carry
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state;
  logic       last;
  logic       id;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] res;
  logic       open;
  logic       take;
  // a new request may be taken when idle or when the pending response drains this cycle
  always_comb begin
    open       = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
    req0_ready = open & req0_valid & (~req1_valid | last);
    req1_ready = open & req1_valid & (~req0_valid | ~last);
    take       = req0_ready | req1_ready;
  end
  // ALU function on the latched operands
  always_comb begin
    res = a + b;
    case (op)
      3'd1: res = {a[6:0], 1'b0};
      3'd2: res = {1'b0, a[7:1]};
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: res = ~(a & b);
      3'd7: res = (a >= b) ? 8'hFF : 8'h00;
      default: res = a + b;
    endcase
  end
`ifdef ALU_ARB_FLAGS_EN
  logic [8:0] sum;
  logic       cy;
  // carry out of add, or the bit shifted out by shl/shr
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    cy  = (op == 3'd0) ? sum[8] : (op == 3'd1) ? a[7] : (op == 3'd2) ? a[0] : 1'b0;
  end
`else
  assign rsp_zero  = 1'b0;
  assign rsp_carry = 1'b0;
`endif
  // sequencer: later assignments override, so an accept in RESP goes straight to EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'h00;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
`endif
    end else begin
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id;
        rsp_data  <= res;
`ifdef ALU_ARB_FLAGS_EN
        rsp_zero  <= (res == 8'h00);
        rsp_carry <= cy;
`endif
        state     <= RESP;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        state     <= IDLE;
      end
      if (take) begin
        op    <= req1_ready ? req1_op : req0_op;
        a     <= req1_ready ? req1_a : req0_a;
        b     <= req1_ready ? req1_b : req0_b;
        id    <= req1_ready;
        last  <= req1_ready;
        state <= EXEC;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, ALU results and reset
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_carry;
  logic [7:0] rsp_data;
  int         checks = 0;
  int         errors = 0;
`ifdef ALU_ARB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif
  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    logic g;
    logic pg;
    cyc();
    cyc();
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_flags", {rsp_zero, rsp_carry}, 0);
    check("rst_rdy", {req0_ready, req1_ready}, 0);
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'h20;
    #1;
    check("add_rdy", {req0_ready, req1_ready}, 9'b10);
    cyc();
    req0_valid = 1'b0;
    #1;
    check("add_exec_rdy", {req0_ready, req1_ready}, 0);
    check("add_exec_valid", rsp_valid, 0);
    cyc();
    #1;
    check("add_valid", rsp_valid, 1);
    check("add_id", rsp_id, 0);
    check("add_data", rsp_data, 9'h10);
    check("add_carry", rsp_carry, FL);
    check("add_zero", rsp_zero, 0);
    cyc();
    #1;
    check("add_drain", rsp_valid, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'hFF; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'h05; req1_b = 8'h06;
    pg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) begin
        g = ((i / 2) % 2) == 1;
        check("rr_rdy", {req0_ready, req1_ready}, g ? 9'b01 : 9'b10);
        if (i >= 2) begin
          check("rr_valid", rsp_valid, 1);
          check("rr_id", rsp_id, pg);
          check("rr_data", rsp_data, pg ? 9'h00 : 9'h0F);
        end
        pg = g;
      end else begin
        check("rr_exec_rdy", {req0_ready, req1_ready}, 0);
        check("rr_exec_valid", rsp_valid, 0);
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("rr_last_data", rsp_data, 9'h00);
    check("rr_last_id", rsp_id, 1);
    cyc();
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h81; req1_b = 8'h55;
    #1;
    check("shl_rdy", req1_ready, 1);
    cyc();
    rsp_ready = 1'b0;
    req1_op = 3'd2;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      check("bp_rdy", {req0_ready, req1_ready}, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 9'h02);
      check("bp_id", rsp_id, 1);
      check("bp_carry", rsp_carry, FL);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_accept", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    check("shr_data", rsp_data, 9'h40);
    check("shr_carry", rsp_carry, FL);
    cyc();
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'hFF; req1_b = 8'hFF;
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    check("nand_data", rsp_data, 9'h00);
    check("nand_zero", rsp_zero, FL);
    check("nand_id", rsp_id, 1);
    cyc();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h0C; req0_b = 8'h30;
    #1;
    check("or_rdy", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    #1;
    check("rexec_valid", rsp_valid, 0);
    check("rexec_data", rsp_data, 0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rexec_grant", {req0_ready, req1_ready}, 9'b10);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    #1;
    check("rexec_id", rsp_id, 0);
    check("rexec_or", rsp_data, 9'h3C);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
